// File: rtl/store_align_buffer_pkg.sv
// Shared definitions for the store-side path: access size encodings
// (also used by the load-side extender) and the buffered entry layout.
package store_align_buffer_pkg;

    // Access size encodings carried with every MEM-stage store or load.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } st_size_e;

    // Entry field widths: word address (byte offset dropped), data, strobes.
    localparam int WADDR_W = 30;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;

    // One queued store, already lane-aligned and ready for the bridge.
    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  data;
        logic [STRB_W-1:0]  strb;
    } st_entry_t;

    // Halfword strobes select the upper or lower lane pair.
    function automatic logic [STRB_W-1:0] half_strb(input logic addr_bit1);
        return addr_bit1 ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Lane table for one store: replicates narrow data across the byte lanes,
// builds the byte strobes and flags misaligned or reserved-size accesses.
module store_lane_gen
    import store_align_buffer_pkg::*;
(
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic              o_misalign
);

    // Decode size and low address bits into lane data, strobes and error.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        o_wdata    = i_data;
        o_wstrb    = '0;
        o_misalign = 1'b0;
        case (st_size_e'(i_size))
            SZ_BYTE: begin
                o_wdata = {4{i_data[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            SZ_HALF: begin
                o_wdata    = {2{i_data[15:0]}};
                o_wstrb    = half_strb(i_addr_lo[1]);
                o_misalign = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_wstrb    = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment buffer between MEM stage and the data-side AXI bridge.
// Aligns each store into lanes/strobes, rejects misaligned ones (AdES) and
// queues the rest in a small FIFO drained over a valid/ready handshake.
// Optional macro STORE_FWD_EN adds a load-address conflict check against
// all queued entries (ld_valid, ld_addr, ld_conflict).
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_err,
    output logic [31:0] st_badvaddr,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    output logic        buf_empty
`ifdef STORE_FWD_EN
    ,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    st_entry_t        r_mem [DEPTH];
    logic             r_st_err;
    logic [31:0]      r_badvaddr;

    logic [31:0]      w_wdata;
    logic [3:0]       w_wstrb;
    logic             w_misalign;
    logic             w_accept;
    logic             w_enq;
    logic             w_deq;
    st_entry_t        w_head;

    store_lane_gen u_lane_gen (
        .i_addr_lo  (st_addr[1:0]),
        .i_size     (st_size),
        .i_data     (st_data),
        .o_wdata    (w_wdata),
        .o_wstrb    (w_wstrb),
        .o_misalign (w_misalign)
    );

    // Full/empty come straight from the registered count; no bypass when full.
    assign st_ready  = (r_count != FULL_CNT);
    assign wr_valid  = (r_count != '0);
    assign buf_empty = (r_count == '0);

    assign w_accept = st_valid && st_ready;
    assign w_enq    = w_accept && !w_misalign;
    assign w_deq    = wr_valid && wr_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage written at the tail on every good store.
    // NOTE: the storage array has no reset; an entry is only observable once
    // the count covers it, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= '{waddr: st_addr[31:2], data: w_wdata, strb: w_wstrb};
        end
    end

    // One-cycle error pulse and sticky faulting address for BadVAddr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st_err   <= 1'b0;
            r_badvaddr <= '0;
        end else begin
            r_st_err <= w_accept && w_misalign;
            if (w_accept && w_misalign) r_badvaddr <= st_addr;
        end
    end

    assign st_err      = r_st_err;
    assign st_badvaddr = r_badvaddr;

    // Head entry drives the bridge; it only moves when the head is taken.
    assign w_head  = r_mem[r_rd_ptr];
    assign wr_addr = {w_head.waddr, 2'b00};
    assign wr_data = w_head.data;
    assign wr_strb = w_head.strb;

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] w_entry_valid;

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        w_entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_entry_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
        end
    end

    // Word-granular match of the load against every live entry; the load's
    // byte offset is reused on the entry side so only bits [31:2] matter.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && ({r_mem[i].waddr, ld_addr[1:0]} == ld_addr)) begin
                ld_conflict = 1'b1;
            end
        end
        ld_conflict = ld_conflict && ld_valid;
    end
`endif

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer with a scoreboard of expected
// bridge writes, compared at the head whenever wr_valid is high.
module tb_store_align_buffer;
    import store_align_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic [31:0] st_badvaddr;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        buf_empty;
`ifdef STORE_FWD_EN
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_conflict;
`endif

    store_align_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_size     (st_size),
        .st_err      (st_err),
        .st_badvaddr (st_badvaddr),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .buf_empty   (buf_empty)
`ifdef STORE_FWD_EN
        ,
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
        step();
        st_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        sb.push_back('{addr: a, data: d, strb: s});
    endtask

    task automatic drain_wait(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Head of queue must match the oldest outstanding expectation, also
    // while stalled, which covers stability under backpressure.
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            if (sb.size() == 0) begin
                check("spurious_wr_valid", {31'b0, wr_valid}, 32'd0);
            end else begin
                check("wr_addr", wr_addr, sb[0].addr);
                check("wr_data", wr_data, sb[0].data);
                check("wr_strb", {28'b0, wr_strb}, {28'b0, sb[0].strb});
                if (wr_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = SZ_BYTE;
        wr_ready = 1'b0;
`ifdef STORE_FWD_EN
        ld_valid = 1'b0;
        ld_addr  = '0;
`endif
        #12;
        check("rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("rst_buf_empty", {31'b0, buf_empty}, 32'd1);
        check("rst_st_ready", {31'b0, st_ready}, 32'd1);
        check("rst_st_err", {31'b0, st_err}, 32'd0);
        check("rst_badvaddr", st_badvaddr, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        wr_ready = 1'b1;
        step();

        // sb to the top byte lane, then it drains and the buffer empties.
        expect_wr(32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        put(32'h0000_1003, 32'h1234_56AB, SZ_BYTE);
        check("sb_wr_valid", {31'b0, wr_valid}, 32'd1);
        check("sb_buf_empty", {31'b0, buf_empty}, 32'd0);
        step();
        check("sb_drained", {31'b0, buf_empty}, 32'd1);

        // Aligned half, then a few more lane patterns back to back.
        expect_wr(32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
        put(32'h0000_2002, 32'hDEAD_BEEF, SZ_HALF);
        expect_wr(32'h0000_4000, 32'hC3C3_C3C3, 4'b0010);
        put(32'h0000_4001, 32'h0000_00C3, SZ_BYTE);
        expect_wr(32'h0000_4000, 32'hA55A_A55A, 4'b0011);
        put(32'h0000_4000, 32'h1111_A55A, SZ_HALF);
        expect_wr(32'h0000_4008, 32'h0123_4567, 4'b1111);
        put(32'h0000_4008, 32'h0123_4567, SZ_WORD);
        drain_wait("lanes_drain");

        // Rejected stores: misaligned half, misaligned word, reserved size.
        put(32'h0000_2001, 32'hDEAD_BEEF, SZ_HALF);
        check("eh_st_err", {31'b0, st_err}, 32'd1);
        check("eh_badvaddr", st_badvaddr, 32'h0000_2001);
        check("eh_not_queued", {31'b0, buf_empty}, 32'd1);
        step();
        check("eh_err_pulse", {31'b0, st_err}, 32'd0);
        check("eh_badvaddr_held", st_badvaddr, 32'h0000_2001);
        put(32'h0000_2006, 32'h5555_5555, SZ_WORD);
        check("ew_st_err", {31'b0, st_err}, 32'd1);
        check("ew_badvaddr", st_badvaddr, 32'h0000_2006);
        put(32'h0000_2008, 32'h6666_6666, SZ_RSVD);
        check("er_st_err", {31'b0, st_err}, 32'd1);
        check("er_badvaddr", st_badvaddr, 32'h0000_2008);
        step();
        check("er_err_pulse", {31'b0, st_err}, 32'd0);
        check("er_not_queued", {31'b0, buf_empty}, 32'd1);

        // Fill to DEPTH under backpressure; the fifth store is refused.
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("fill_st_ready", {31'b0, st_ready}, (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) expect_wr(32'h0000_5000 + 32'(i * 4), 32'hF000_0000 + 32'(i), 4'b1111);
            st_valid = 1'b1;
            st_addr  = 32'h0000_5000 + 32'(i * 4);
            st_data  = 32'hF000_0000 + 32'(i);
            st_size  = SZ_WORD;
            step();
        end
        st_valid = 1'b0;
        check("full_st_ready", {31'b0, st_ready}, 32'd0);
        repeat (3) step();
        wr_ready = 1'b1;
        drain_wait("full_drain");
        check("full_buf_empty", {31'b0, buf_empty}, 32'd1);

        // Two queued, then simultaneous accept and drain for ten cycles.
        wr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_wr(32'h0000_6000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111);
            put(32'h0000_6000 + 32'(i * 4), 32'hA000_0000 + 32'(i), SZ_WORD);
        end
        wr_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            check("flow_st_ready", {31'b0, st_ready}, 32'd1);
            check("flow_not_empty", {31'b0, buf_empty}, 32'd0);
            expect_wr(32'h0000_6000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111);
            st_valid = 1'b1;
            st_addr  = 32'h0000_6000 + 32'(i * 4);
            st_data  = 32'hA000_0000 + 32'(i);
            st_size  = SZ_WORD;
            step();
        end
        st_valid = 1'b0;
        check("flow_pending", 32'(sb.size()), 32'd2);
        drain_wait("flow_drain");

        // Reset with three entries queued drops them immediately.
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_wr(32'h0000_7000 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'b1111);
            put(32'h0000_7000 + 32'(i * 4), 32'hB000_0000 + 32'(i), SZ_WORD);
        end
        check("pre_rst_wr_valid", {31'b0, wr_valid}, 32'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_rst_wr_valid", {31'b0, wr_valid}, 32'd0);
        check("async_rst_buf_empty", {31'b0, buf_empty}, 32'd1);
        check("async_rst_badvaddr", st_badvaddr, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        wr_ready = 1'b1;
        repeat (5) step();
        check("post_rst_buf_empty", {31'b0, buf_empty}, 32'd1);
        check("post_rst_st_ready", {31'b0, st_ready}, 32'd1);

`ifdef STORE_FWD_EN
        // Load conflict against a queued word store.
        wr_ready = 1'b0;
        expect_wr(32'h0000_3000, 32'hCAFE_F00D, 4'b1111);
        put(32'h0000_3000, 32'hCAFE_F00D, SZ_WORD);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3002;
        #1;
        check("fwd_hit", {31'b0, ld_conflict}, 32'd1);
        ld_addr = 32'h0000_3004;
        #1;
        check("fwd_other_word", {31'b0, ld_conflict}, 32'd0);
        ld_addr = 32'h0000_3002;
        ld_valid = 1'b0;
        #1;
        check("fwd_no_load", {31'b0, ld_conflict}, 32'd0);
        ld_valid = 1'b1;
        wr_ready = 1'b1;
        drain_wait("fwd_drain");
        check("fwd_cleared", {31'b0, ld_conflict}, 32'd0);
        ld_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
